// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg
//   Shared definitions for the data-memory arbiter:
//     arb_state_e     - arbitration state (ARB, LOCKED)
//     P0 / P1         - port index constants (pipeline MEM stage / loader-debug)
//     WORD_ALIGN_MASK - low address bits that must be zero for a word access
//     is_aligned()    - word-alignment test for a byte address
package dmem_arbiter_pkg;

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int P0 = 0;
  localparam int P1 = 1;

  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  function automatic logic is_aligned(input logic [31:0] addr);
    return (addr[1:0] & WORD_ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/dmem_rsp_reg.sv
// dmem_rsp_reg
//   Per-port response register. Turns a granted access into the registered
//   response seen one cycle after the grant edge.
//   Ports:
//     clk, rst_n       - clock, asynchronous active-low reset
//     gnt              - this port was granted this cycle
//     we               - granted access is a write
//     aligned          - granted address is word aligned
//     mem_rdata        - combinational memory read data
//     rvalid, rdata    - read response (rdata holds until the next valid read)
//     err              - one-cycle misaligned-access pulse
module dmem_rsp_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        gnt,
  input  logic        we,
  input  logic        aligned,
  input  logic [31:0] mem_rdata,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        err
);

  logic read_hit;

  // Only an aligned read produces data; a misaligned access of either kind
  // is consumed and reported through err instead.
  assign read_hit = gnt && !we && aligned;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      err    <= 1'b0;
    end else begin
      rvalid <= read_hit;
      err    <= gnt && !aligned;
      if (read_hit) begin
        rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Two-port arbiter in front of a single-ported data memory.
//   Port 0 (pipeline MEM stage) normally has priority; port 1 (loader/debug)
//   is protected from starvation and may lock the memory for bursts.
//   Parameters:
//     STARVE_MAX - contested cycles port 1 may lose before it is forced to win
//     LOCK_MAX   - maximum number of cycles port 1 may hold a lock
//   Ports:
//     clk, rst_n                         - clock, asynchronous active-low reset
//     pX_req/pX_we/pX_addr/pX_wdata      - per-port request
//     p1_lock                            - port 1 burst ownership request
//     pX_gnt                             - combinational grant
//     pX_rvalid/pX_rdata/pX_err          - registered responses
//     mem_we/mem_addr/mem_wdata/mem_rdata - memory side
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int LOCK_MAX   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic        p1_lock,
  output logic        p0_gnt,
  output logic        p1_gnt,
  output logic        p0_rvalid,
  output logic        p1_rvalid,
  output logic [31:0] p0_rdata,
  output logic [31:0] p1_rdata,
  output logic        p0_err,
  output logic        p1_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam int LW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
  localparam logic [LW-1:0] LOCK_TOP   = LW'(LOCK_MAX - 1);

  arb_state_e    state, state_next;
  logic [SW-1:0] starve_cnt, starve_cnt_next;
  logic [LW-1:0] lock_cnt, lock_cnt_next;
  logic [1:0]    gnt;

  // Port-indexed views so both response registers come from one generate loop.
  logic [1:0]  req_v;
  logic [1:0]  we_v;
  logic [31:0] addr_v   [2];
  logic [31:0] wdata_v  [2];
  logic [1:0]  rvalid_v;
  logic [31:0] rdata_v  [2];
  logic [1:0]  err_v;

  assign req_v[P0]   = p0_req;
  assign req_v[P1]   = p1_req;
  assign we_v[P0]    = p0_we;
  assign we_v[P1]    = p1_we;
  assign addr_v[P0]  = p0_addr;
  assign addr_v[P1]  = p1_addr;
  assign wdata_v[P0] = p0_wdata;
  assign wdata_v[P1] = p1_wdata;

  // Grant decision. rst_n gates the grants so nothing reaches the memory
  // while reset is held, independent of the (already cleared) state.
  always_comb begin
    gnt = 2'b00;
    if (rst_n) begin
      case (state)
        ARB: begin
          if (req_v[P0] && req_v[P1]) begin
            if (starve_cnt == STARVE_TOP) gnt[P1] = 1'b1;
            else                          gnt[P0] = 1'b1;
          end else if (req_v[P0]) begin
            gnt[P0] = 1'b1;
          end else if (req_v[P1]) begin
            gnt[P1] = 1'b1;
          end
        end
        LOCKED: begin
          gnt[P1] = req_v[P1];
        end
        default: gnt = 2'b00;
      endcase
    end
  end

  assign p0_gnt = gnt[P0];
  assign p1_gnt = gnt[P1];

  // Memory-side mux; an idle cycle drives all zeros.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt[P0]) begin
      mem_we    = we_v[P0] && is_aligned(addr_v[P0]);
      mem_addr  = addr_v[P0];
      mem_wdata = wdata_v[P0];
    end else if (gnt[P1]) begin
      mem_we    = we_v[P1] && is_aligned(addr_v[P1]);
      mem_addr  = addr_v[P1];
      mem_wdata = wdata_v[P1];
    end
  end

  // State and lock counter. The lock ends on the edge that sees p1_lock low
  // or the last permitted locked cycle, so the next cycle is a normal ARB
  // cycle in which port 0 has priority again.
  always_comb begin
    state_next    = state;
    lock_cnt_next = lock_cnt;
    case (state)
      ARB: begin
        if (gnt[P1] && p1_lock) begin
          state_next    = LOCKED;
          lock_cnt_next = '0;
        end
      end
      LOCKED: begin
        if (!p1_lock || lock_cnt == LOCK_TOP) begin
          state_next    = ARB;
          lock_cnt_next = '0;
        end else begin
          lock_cnt_next = lock_cnt + 1'b1;
        end
      end
      default: begin
        state_next    = ARB;
        lock_cnt_next = '0;
      end
    endcase
  end

  // Starvation counter: counts denied port-1 requests, saturating, and is
  // cleared by any port-1 grant (including grants while locked).
  always_comb begin
    starve_cnt_next = starve_cnt;
    if (gnt[P1]) begin
      starve_cnt_next = '0;
    end else if (req_v[P1] && starve_cnt != STARVE_TOP) begin
      starve_cnt_next = starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB;
      starve_cnt <= '0;
      lock_cnt   <= '0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_cnt_next;
      lock_cnt   <= lock_cnt_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rsp
      dmem_rsp_reg u_rsp (
        .clk       (clk),
        .rst_n     (rst_n),
        .gnt       (gnt[gi]),
        .we        (we_v[gi]),
        .aligned   (is_aligned(addr_v[gi])),
        .mem_rdata (mem_rdata),
        .rvalid    (rvalid_v[gi]),
        .rdata     (rdata_v[gi]),
        .err       (err_v[gi])
      );
    end
  endgenerate

  assign p0_rvalid = rvalid_v[P0];
  assign p1_rvalid = rvalid_v[P1];
  assign p0_rdata  = rdata_v[P0];
  assign p1_rdata  = rdata_v[P1];
  assign p0_err    = err_v[P0];
  assign p1_err    = err_v[P1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Directed bench for dmem_arbiter with default parameters (STARVE_MAX=4,
//   LOCK_MAX=16). A small word memory (word i reset to value i) sits on the
//   memory port.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        p0_req, p0_we, p1_req, p1_we, p1_lock;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [0:63];

  int checks   = 0;
  int failures = 0;

  dmem_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .p0_req    (p0_req),
    .p0_we     (p0_we),
    .p0_addr   (p0_addr),
    .p0_wdata  (p0_wdata),
    .p1_req    (p1_req),
    .p1_we     (p1_we),
    .p1_addr   (p1_addr),
    .p1_wdata  (p1_wdata),
    .p1_lock   (p1_lock),
    .p0_gnt    (p0_gnt),
    .p1_gnt    (p1_gnt),
    .p0_rvalid (p0_rvalid),
    .p1_rvalid (p1_rvalid),
    .p0_rdata  (p0_rdata),
    .p1_rdata  (p1_rdata),
    .p0_err    (p0_err),
    .p1_err    (p1_err),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: word i holds i after reset; writes land on the clock edge.
  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'(i);
    end else if (mem_we) begin
      mem[mem_addr[7:2]] <= mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  task automatic set_p0(input logic req, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata);
    p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata;
  endtask

  task automatic set_p1(input logic req, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic lock);
    p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_lock = lock;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    set_p0(1'b1, 1'b1, 32'h0, 32'hAAAA);
    set_p1(1'b1, 1'b1, 32'h4, 32'hBBBB, 1'b1);
    tick(); tick(); tick();

    // ---- reset state: no grants or writes while held, responses cleared ----
    chk("rst_p0_gnt", 32'(p0_gnt), 32'd0);
    chk("rst_p1_gnt", 32'(p1_gnt), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_rvalid", {30'd0, p1_rvalid, p0_rvalid}, 32'd0);
    chk("rst_err", {30'd0, p1_err, p0_err}, 32'd0);
    chk("rst_p0_rdata", p0_rdata, 32'd0);

    set_p0(1'b0, 1'b0, 32'h0, 32'h0);
    set_p1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("idle_mem_addr", mem_addr, 32'd0);
    tick();

    // ---- p0 read of 0x8 alone, memory returns 2 ----
    set_p0(1'b1, 1'b0, 32'h8, 32'h0);
    #1;
    chk("rd_p0_gnt", 32'(p0_gnt), 32'd1);
    chk("rd_mem_addr", mem_addr, 32'h8);
    tick();
    set_p0(1'b0, 1'b0, 32'h0, 32'h0);
    chk("rd_p0_rvalid", 32'(p0_rvalid), 32'd1);
    chk("rd_p0_rdata", p0_rdata, 32'd2);
    tick();
    chk("rd_rvalid_pulse", 32'(p0_rvalid), 32'd0);
    chk("rd_rdata_hold", p0_rdata, 32'd2);

    // ---- misaligned p0 write to 0x6 ----
    set_p0(1'b1, 1'b1, 32'h6, 32'h5555);
    #1;
    chk("mis_p0_gnt", 32'(p0_gnt), 32'd1);
    chk("mis_mem_we", 32'(mem_we), 32'd0);
    tick();
    set_p0(1'b0, 1'b0, 32'h0, 32'h0);
    chk("mis_p0_err", 32'(p0_err), 32'd1);
    chk("mis_p0_rvalid", 32'(p0_rvalid), 32'd0);
    chk("mis_rdata_hold", p0_rdata, 32'd2);
    chk("mis_mem_word1", mem[1], 32'd1);
    tick();
    chk("mis_err_pulse", 32'(p0_err), 32'd0);

    // ---- aligned p0 write to 0x20 ----
    set_p0(1'b1, 1'b1, 32'h20, 32'h1234);
    #1;
    chk("wr_mem_we", 32'(mem_we), 32'd1);
    chk("wr_mem_wdata", mem_wdata, 32'h1234);
    tick();
    set_p0(1'b0, 1'b0, 32'h0, 32'h0);
    chk("wr_mem_word8", mem[8], 32'h1234);
    chk("wr_no_rvalid", 32'(p0_rvalid), 32'd0);

    // ---- both requesting: p0 x4, p1 x1, repeated ----
    set_p0(1'b1, 1'b0, 32'h0, 32'h0);
    set_p1(1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      #1;
      chk($sformatf("starve_p0_gnt_c%0d", c), 32'(p0_gnt), (c % 5 == 4) ? 32'd0 : 32'd1);
      chk($sformatf("starve_p1_gnt_c%0d", c), 32'(p1_gnt), (c % 5 == 4) ? 32'd1 : 32'd0);
      tick();
      if (c == 4) begin
        chk("starve_p1_rvalid", 32'(p1_rvalid), 32'd1);
        chk("starve_p1_rdata", p1_rdata, 32'd1);
      end
    end
    set_p0(1'b0, 1'b0, 32'h0, 32'h0);
    set_p1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    tick();

    // ---- p1 locked write of 0xDEAD to 0x10, p0 kept waiting ----
    set_p1(1'b1, 1'b1, 32'h10, 32'hDEAD, 1'b1);
    #1;
    chk("lk_entry_p1_gnt", 32'(p1_gnt), 32'd1);
    chk("lk_entry_mem_we", 32'(mem_we), 32'd1);
    tick();
    set_p0(1'b1, 1'b0, 32'h8, 32'h0);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("lk_p0_denied_c%0d", c), 32'(p0_gnt), 32'd0);
      chk($sformatf("lk_p1_gnt_c%0d", c), 32'(p1_gnt), 32'd1);
      tick();
    end
    chk("lk_mem_word4", mem[4], 32'hDEAD);
    // lock drops: this cycle is still locked, the next is arbitrated normally
    set_p1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    #1;
    chk("lk_fall_p0_gnt", 32'(p0_gnt), 32'd0);
    tick();
    #1;
    chk("lk_after_p0_gnt", 32'(p0_gnt), 32'd1);
    tick();
    set_p0(1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    // ---- lock held forever: forced release after 16 locked cycles ----
    set_p1(1'b1, 1'b0, 32'h10, 32'h0, 1'b1);
    #1;
    chk("lmax_entry_p1_gnt", 32'(p1_gnt), 32'd1);
    tick();
    set_p0(1'b1, 1'b0, 32'h0, 32'h0);
    for (int c = 0; c < 16; c++) begin
      #1;
      chk($sformatf("lmax_p1_gnt_c%0d", c), 32'(p1_gnt), 32'd1);
      chk($sformatf("lmax_p0_gnt_c%0d", c), 32'(p0_gnt), 32'd0);
      tick();
    end
    #1;
    chk("lmax_release_p0_gnt", 32'(p0_gnt), 32'd1);
    chk("lmax_release_p1_gnt", 32'(p1_gnt), 32'd0);
    tick();

    // ---- reset pulsed while locked ----
    set_p0(1'b0, 1'b0, 32'hC, 32'h0);
    #1;
    chk("rl_entry_p1_gnt", 32'(p1_gnt), 32'd1);
    tick();
    set_p0(1'b1, 1'b0, 32'hC, 32'h0);
    #1;
    chk("rl_locked_p0_gnt", 32'(p0_gnt), 32'd0);
    chk("rl_locked_p1_gnt", 32'(p1_gnt), 32'd1);
    tick();
    chk("rl_p1_rvalid", 32'(p1_rvalid), 32'd1);
    chk("rl_p1_rdata", p1_rdata, 32'hDEAD);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rl_async_p1_rvalid", 32'(p1_rvalid), 32'd0);
    chk("rl_async_p1_rdata", p1_rdata, 32'd0);
    chk("rl_async_gnt", {30'd0, p1_gnt, p0_gnt}, 32'd0);
    chk("rl_async_mem_we", 32'(mem_we), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chk("rl_release_p0_gnt", 32'(p0_gnt), 32'd1);
    chk("rl_release_p1_gnt", 32'(p1_gnt), 32'd0);
    tick();
    chk("rl_p0_rvalid", 32'(p0_rvalid), 32'd1);
    chk("rl_p0_rdata", p0_rdata, 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
